accum_buffer: RTL

ACCUM_BUFFER -- requirements
Module: accum_buffer

---
 rtl/accum_pkg.sv | 22 ++
 rtl/accum_sat_add.sv | 33 +++
 rtl/accum_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulation buffer: FSM state encoding,
// default geometry, and the signed clamp bounds used when ACCUM_SATURATE_EN is set.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_ACC_W = 20;

  function automatic logic signed [32:0] sat_max(input int w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [32:0] sat_min(input int w);
    return -(33'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational W-bit signed adder; ACCUM_SATURATE_EN selects clamping to the
// W-bit signed range, otherwise the sum wraps in two's complement.
module accum_sat_add
  import accum_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

`ifdef ACCUM_SATURATE_EN
  localparam logic signed [32:0] MAXV = sat_max(W);
  localparam logic signed [32:0] MINV = sat_min(W);

  logic signed [W:0] sum_ext;

  always_comb begin
    sum_ext = {a[W-1], a} + {b[W-1], b};
    if (sum_ext > MAXV) begin
      sum = MAXV[W-1:0];
    end else if (sum_ext < MINV) begin
      sum = MINV[W-1:0];
    end else begin
      sum = sum_ext[W-1:0];
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/accum_buffer.sv
// Row accumulation buffer: collects (col0,col1) rows with overwrite/accumulate, then
// drains them over a valid/ready stream. ACCUM_SATURATE_EN selects clamping over wrap.
module accum_buffer
  import accum_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      accumulate,
  input  logic                      wr_rewind,
  input  logic                      in_valid,
  input  logic signed [15:0]        in_col0,
  input  logic signed [15:0]        in_col1,
  input  logic                      drain,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_col0,
  output logic signed [ACC_W-1:0]   out_col1,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  state_t            state_q, state_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  acc_t              out0_q, out0_d;
  acc_t              out1_q, out1_d;

  acc_t              mem0_q [DEPTH];
  acc_t              mem1_q [DEPTH];

  ptr_t              wr_base, wr_nxt;
  logic              wr_full, wr_en;
  logic [AW-1:0]     wr_idx, nxt_a;
  acc_t              in0_ext, in1_ext, add_a0, add_a1, new0, new1, row0, row1;

  always_comb begin
    wr_base = wr_rewind ? '0 : wr_ptr_q;
    wr_nxt  = wr_base + ptr_t'(1);
    wr_full = (wr_base == ptr_t'(DEPTH));
    wr_en   = in_valid && !clear && (state_q != ST_DRAIN) && !wr_full;
    wr_idx  = wr_base[AW-1:0];
    in0_ext = {{(ACC_W-16){in_col0[15]}}, in_col0};
    in1_ext = {{(ACC_W-16){in_col1[15]}}, in_col1};
    // Entries not written since the last clear/drain count as zero.
    add_a0  = (accumulate && vld_q[wr_idx]) ? mem0_q[wr_idx] : '0;
    add_a1  = (accumulate && vld_q[wr_idx]) ? mem1_q[wr_idx] : '0;
  end

  accum_sat_add #(.W(ACC_W)) u_add0 (.a(add_a0), .b(in0_ext), .sum(new0));
  accum_sat_add #(.W(ACC_W)) u_add1 (.a(add_a1), .b(in1_ext), .sum(new1));

  // Row to present next; bypass covers a write landing in the drain-accept cycle.
  always_comb begin
    nxt_a = (state_q == ST_DRAIN) ? rd_ptr_q + 1'b1 : '0;
    if (wr_en && (wr_idx == nxt_a)) begin
      row0 = new0;
      row1 = new1;
    end else begin
      row0 = vld_q[nxt_a] ? mem0_q[nxt_a] : '0;
      row1 = vld_q[nxt_a] ? mem1_q[nxt_a] : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    vld_d       = vld_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out0_d      = out0_q;
    out1_d      = out1_q;

    if (clear) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      count_d     = '0;
      vld_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (in_valid && !wr_en) begin
        ovf_d = 1'b1;
      end
      if (wr_rewind && (state_q != ST_DRAIN)) begin
        wr_ptr_d = '0;
      end
      if (wr_en) begin
        wr_ptr_d      = wr_nxt;
        vld_d[wr_idx] = 1'b1;
        if (wr_nxt > count_q) begin
          count_d = wr_nxt;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          if (drain && (count_d != '0)) begin
            state_d     = ST_DRAIN;
            rd_ptr_d    = '0;
            out_valid_d = 1'b1;
            out0_d      = row0;
            out1_d      = row1;
            out_last_d  = ({1'b0, nxt_a} + ptr_t'(1)) == count_d;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              wr_ptr_d    = '0;
              count_d     = '0;
              vld_d       = '0;
            end else begin
              rd_ptr_d   = nxt_a;
              out0_d     = row0;
              out1_d     = row1;
              out_last_d = ({1'b0, nxt_a} + ptr_t'(1)) == count_d;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      vld_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      vld_q       <= vld_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem0_q[wr_idx] <= new0;
      mem1_q[wr_idx] <= new1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_col0  = out0_q;
  assign out_col1  = out1_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;

endmodule
